// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the refclk domain.
// Pulses PLL reset, waits for stable lock, retries on timeout.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       req_relock,
  output logic       pll_rst,
  output logic       sys_rst_req,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam int PH_MAX =
    (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int PH_W =
    (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TO_W =
    (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [PH_W-1:0] PH_TOP  = PH_W'(PH_MAX - 1);
  localparam logic [PH_W-1:0] RST_TOP = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] STB_TOP = PH_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0] TO_TOP  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [2:0]      RET_MAX = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [1:0]      sync;
  logic            locked_s;
  logic [PH_W-1:0] ph_cnt, ph_n;
  logic [TO_W-1:0] to_cnt, to_n;
  logic [2:0]      retry_n;
  logic            timeout;
  logic            in_lock_w, nx_lock_w;

  assign locked_s = sync[1];

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], pll_locked};
  end

  // State, counters and retry count registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= ST_RST_PLL;
      ph_cnt    <= '0;
      to_cnt    <= '0;
      retry_cnt <= 3'd0;
    end else begin
      state     <= state_n;
      ph_cnt    <= ph_n;
      to_cnt    <= to_n;
      retry_cnt <= retry_n;
    end
  end

  // Next-state, retry and saturating counter logic.
  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    timeout = 1'b0;
    unique case (state)
      ST_RST_PLL: begin
        if (ph_cnt == RST_TOP) state_n = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s)              state_n = ST_STABLE;
        else if (to_cnt == TO_TOP) timeout = 1'b1;
      end
      ST_STABLE: begin
        if (!locked_s)              state_n = ST_WAIT_LOCK;
        else if (ph_cnt == STB_TOP) state_n = ST_RUN;
        else if (to_cnt == TO_TOP)  timeout = 1'b1;
      end
      ST_RUN: begin
        if (!locked_s || req_relock) state_n = ST_RST_PLL;
      end
      ST_FAIL: begin
        if (req_relock) begin
          state_n = ST_RST_PLL;
          retry_n = 3'd0;
        end
      end
      default: state_n = ST_RST_PLL;
    endcase

    if (timeout) begin
      if (retry_cnt == RET_MAX) begin
        state_n = ST_FAIL;
      end else begin
        state_n = ST_RST_PLL;
        retry_n = retry_cnt + 3'd1;
      end
    end

    if (state_n == ST_RUN && state != ST_RUN) retry_n = 3'd0;

    // Lock timer spans WAIT_LOCK/STABLE back-and-forth.
    in_lock_w = (state == ST_WAIT_LOCK) || (state == ST_STABLE);
    nx_lock_w = (state_n == ST_WAIT_LOCK) || (state_n == ST_STABLE);
    if (in_lock_w && nx_lock_w)
      to_n = (to_cnt == TO_TOP) ? to_cnt : to_cnt + 1'b1;
    else
      to_n = '0;

    if (state_n != state)
      ph_n = '0;
    else
      ph_n = (ph_cnt == PH_TOP) ? ph_cnt : ph_cnt + 1'b1;
  end

  assign pll_rst     = (state == ST_RST_PLL);
  assign ready       = (state == ST_RUN);
  assign sys_rst_req = (state != ST_RUN);
  assign fail        = (state == ST_FAIL);
  assign state_dbg   = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed scoreboard bench for pll_lock_sequencer.
// Small parameters keep every scenario short.
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int TO = 40;
  localparam int LS = 8;
  localparam int MR = 2;

  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic req_relock = 1'b0;
  logic pll_rst, sys_rst_req, ready, fail;
  logic [2:0] retry_cnt, state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb[$];

  int rst_entries = 0;
  logic [2:0] prev_st = 3'd0;

  pll_lock_sequencer #(
    .RST_CYCLES  (RC),
    .LOCK_TIMEOUT(TO),
    .LOCK_STABLE (LS),
    .MAX_RETRIES (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .req_relock (req_relock),
    .pll_rst    (pll_rst),
    .sys_rst_req(sys_rst_req),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .state_dbg  (state_dbg)
  );

  always #5 refclk = ~refclk;

  // Count entries into RST_PLL.
  always @(state_dbg) begin
    if (state_dbg == 3'd0 && prev_st != 3'd0) rst_entries++;
    prev_st = state_dbg;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic push(input string t, input int v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input int obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed %0d expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic wait_state(input logic [2:0] st,
                            input int budget,
                            output int n);
    n = 0;
    while (state_dbg !== st && n < budget) begin
      @(negedge refclk);
      n++;
    end
    if (state_dbg !== st) n = -1;
  endtask

  task automatic chk_outs(input string t,
                          input logic [2:0] st,
                          input logic [2:0] rc);
    push({t, "_state"}, int'(st));
    check(int'(state_dbg));
    push({t, "_pll_rst"}, int'(st == 3'd0));
    check(int'(pll_rst));
    push({t, "_sys_rst_req"}, int'(st != 3'd3));
    check(int'(sys_rst_req));
    push({t, "_ready"}, int'(st == 3'd3));
    check(int'(ready));
    push({t, "_fail"}, int'(st == 3'd4));
    check(int'(fail));
    push({t, "_retry"}, int'(rc));
    check(int'(retry_cnt));
  endtask

  initial begin
    int n;
    int e0;

    tick(2);
    chk_outs("reset", 3'd0, 3'd0);

    // 1: release, lock rises 10 cycles later
    rst = 1'b0;
    push("s1_pll_rst_len", RC);
    wait_state(3'd1, 20, n);
    check(n);
    tick(6);
    pll_locked = 1'b1;
    tick(1);
    push("s1_lock_to_run", LS + 2);
    wait_state(3'd3, 100, n);
    check(n);
    chk_outs("s1_run", 3'd3, 3'd0);

    // 4: lock loss in RUN
    pll_locked = 1'b0;
    tick(1);
    push("s4_loss_to_rst", 2);
    wait_state(3'd0, 20, n);
    check(n);
    chk_outs("s4_rst", 3'd0, 3'd0);
    push("s4_pll_rst_len", RC);
    wait_state(3'd1, 20, n);
    check(n);
    pll_locked = 1'b1;
    tick(1);
    push("s4_relock_run", LS + 2);
    wait_state(3'd3, 100, n);
    check(n);
    chk_outs("s4_run", 3'd3, 3'd0);

    // 5: relock coincident with lock loss
    e0 = rst_entries;
    pll_locked = 1'b0;
    tick(2);
    req_relock = 1'b1;
    tick(1);
    req_relock = 1'b0;
    chk_outs("s5_rst", 3'd0, 3'd0);
    push("s5_pll_rst_len", RC);
    wait_state(3'd1, 20, n);
    check(n);
    push("s5_entries", 1);
    check(rst_entries - e0);
    req_relock = 1'b1;
    tick(1);
    req_relock = 1'b0;
    tick(2);
    chk_outs("s5_wait_relock", 3'd1, 3'd0);
    push("s5_entries_after", 1);
    check(rst_entries - e0);
    pll_locked = 1'b1;
    tick(1);
    push("s5_run", LS + 2);
    wait_state(3'd3, 100, n);
    check(n);

    // 3: one-cycle lock drop at stable count 5
    req_relock = 1'b1;
    tick(1);
    req_relock = 1'b0;
    chk_outs("s3_rst", 3'd0, 3'd0);
    push("s3_pll_rst_len", RC);
    wait_state(3'd1, 20, n);
    check(n);
    push("s3_to_stable", 1);
    wait_state(3'd2, 20, n);
    check(n);
    tick(3);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(2);
    chk_outs("s3_glitch", 3'd1, 3'd0);
    push("s3_to_cnt_kept", 7);
    check(int'(dut.to_cnt));
    push("s3_rerun", LS + 1);
    wait_state(3'd3, 100, n);
    check(n);
    chk_outs("s3_run", 3'd3, 3'd0);

    // 2: lock never returns, retries then FAIL
    pll_locked = 1'b0;
    tick(1);
    push("s2_loss_to_rst", 2);
    wait_state(3'd0, 20, n);
    check(n);
    for (int k = 1; k <= MR; k++) begin
      push("s2_pll_rst_len", RC);
      wait_state(3'd1, 20, n);
      check(n);
      push("s2_timeout", TO);
      wait_state(3'd0, 100, n);
      check(n);
      chk_outs("s2_retry", 3'd0, 3'(k));
    end
    push("s2_pll_rst_len", RC);
    wait_state(3'd1, 20, n);
    check(n);
    push("s2_fail_timeout", TO);
    wait_state(3'd4, 100, n);
    check(n);
    chk_outs("s2_fail", 3'd4, 3'(MR));
    tick(20);
    chk_outs("s2_fail_hold", 3'd4, 3'(MR));
    req_relock = 1'b1;
    tick(1);
    req_relock = 1'b0;
    chk_outs("s2_relock", 3'd0, 3'd0);

    // 6: asynchronous reset mid-STABLE
    pll_locked = 1'b1;
    push("s6_to_stable", RC + 1);
    wait_state(3'd2, 50, n);
    check(n);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("s6_async", 3'd0, 3'd0);
    tick(1);
    rst = 1'b0;
    push("s6_pll_rst_len", RC);
    wait_state(3'd1, 20, n);
    check(n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
